// File: rtl/hs_lb_pkg.sv
// Shared constants and helpers for the load-balancing stream blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hs_lb_pkg;

    localparam int N_OUT_MAX = 16;
    localparam int STAT_W    = 32;

    // Round-robin increment that wraps at n-1 back to 0. It never steps into
    // encodings >= n, which matters when n is not a power of two.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/hs_handshake_inf.sv
// Valid/ready stream bundle carrying one payload of type T per handshake.
// Latency: n/a (wires only).
// Backpressure: a transfer happens on a cycle with valid && ready; m drives valid/data, s drives ready.
interface HandshakeInf #(
    parameter type T = logic [63:0]
) ();
    logic valid;
    logic ready;
    T     data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

// File: rtl/hs_skid_buf.sv
// 2-entry stream FIFO with a registered ingress ready.
// Latency: 1 cycle from accept to head valid.
// Backpressure: s.ready is high while occupancy after the current edge is < 2.
// Ports: aclk, reset (sync, active-high), s (ingress), m (head of FIFO),
//        level_nxt (occupancy after the current edge, for status logic).
module hs_skid_buf #(
    parameter type STYPE = logic [63:0]
) (
    input  logic       aclk,
    input  logic       reset,
    HandshakeInf.s     s,
    HandshakeInf.m     m,
    output logic [1:0] level_nxt
);

    STYPE       mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] level;
    logic       rdy_q;
    logic       push;
    logic       pop;

    assign push      = s.valid && rdy_q;
    assign pop       = m.valid && m.ready;
    assign level_nxt = level + {1'b0, push} - {1'b0, pop};

    assign s.ready = rdy_q;
    assign m.valid = (level != 2'd0);
    assign m.data  = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
            rdy_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s.data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            level <= level_nxt;
            // Ready is computed from the next occupancy so it is exact
            // without a combinational path from the drain side.
            rdy_q <= (level_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/hs_rr_dispatch.sv
// Round-robin dispatcher: one ingress stream fanned out to N_OUT egress streams.
// Latency: 2 cycles from ingress accept to egress valid; 1 item/cycle sustained.
// Backpressure: registered on both sides; a busy egress slot is skipped, ingress stalls when the 2-entry buffer fills.
// Ports: aclk, reset (sync, active-high), s_in, m_out[N_OUT], last_port, idle.
// Optional build macro HS_RR_DISPATCH_STATS_EN adds dispatch_cnt[N_OUT] and stall_cnt.
module hs_rr_dispatch
    import hs_lb_pkg::*;
#(
    parameter int  N_OUT = 4,
    parameter type STYPE = logic [63:0],
    localparam int PTR_W = $clog2(N_OUT)
) (
    input  logic              aclk,
    input  logic              reset,
    HandshakeInf.s            s_in,
    HandshakeInf.m            m_out [N_OUT],
    output logic [PTR_W-1:0]  last_port,
    output logic              idle
`ifdef HS_RR_DISPATCH_STATS_EN
    ,
    output logic [STAT_W-1:0] dispatch_cnt [N_OUT],
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    HandshakeInf #(.T(STYPE)) head ();
    logic [1:0] buf_level_nxt;

    hs_skid_buf #(.STYPE(STYPE)) u_skid (
        .aclk      (aclk),
        .reset     (reset),
        .s         (s_in),
        .m         (head),
        .level_nxt (buf_level_nxt)
    );

    logic [N_OUT-1:0] slot_vld;
    logic [N_OUT-1:0] slot_vld_nxt;
    logic [N_OUT-1:0] slot_load;
    logic [N_OUT-1:0] out_rdy;
    logic [N_OUT-1:0] slot_free;
    STYPE             slot_dat [N_OUT];
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] sel;
    logic             found;
    logic             dispatch;
    int               scan_idx;

    for (genvar g = 0; g < N_OUT; g++) begin : g_port
        assign out_rdy[g]     = m_out[g].ready;
        assign m_out[g].valid = slot_vld[g];
        assign m_out[g].data  = slot_dat[g];
    end

    // A slot draining this cycle can be refilled on the same edge.
    assign slot_free = ~slot_vld | out_rdy;

    // First free slot at or after rr_ptr, wrapping at N_OUT.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = 0;
        for (int off = 0; off < N_OUT; off++) begin
            scan_idx = int'(rr_ptr) + off;
            if (scan_idx >= N_OUT) begin
                scan_idx = scan_idx - N_OUT;
            end
            if (!found && slot_free[PTR_W'(scan_idx)]) begin
                found = 1'b1;
                sel   = PTR_W'(scan_idx);
            end
        end
    end

    assign dispatch   = head.valid && found;
    assign head.ready = dispatch;

    always_comb begin
        slot_load    = '0;
        slot_vld_nxt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            slot_load[i]    = dispatch && (sel == PTR_W'(i));
            slot_vld_nxt[i] = slot_load[i] || (slot_vld[i] && !out_rdy[i]);
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            slot_vld  <= '0;
            rr_ptr    <= '0;
            last_port <= '0;
            idle      <= 1'b1;
            for (int i = 0; i < N_OUT; i++) begin
                slot_dat[i] <= '0;
            end
        end else begin
            slot_vld <= slot_vld_nxt;
            for (int i = 0; i < N_OUT; i++) begin
                if (slot_load[i]) begin
                    slot_dat[i] <= head.data;
                end
            end
            if (dispatch) begin
                rr_ptr    <= PTR_W'(rr_next(32'(sel), 32'(N_OUT)));
                last_port <= sel;
            end
            idle <= (buf_level_nxt == 2'd0) && (slot_vld_nxt == '0);
        end
    end

`ifdef HS_RR_DISPATCH_STATS_EN
    always_ff @(posedge aclk) begin
        if (reset) begin
            stall_cnt <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                dispatch_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (slot_load[i]) begin
                    dispatch_cnt[i] <= dispatch_cnt[i] + STAT_W'(1);
                end
            end
            if (head.valid && !found) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hs_rr_dispatch.sv
// Directed bench for hs_rr_dispatch (N_OUT=4 and N_OUT=3 instances).
// Latency: n/a.
// Backpressure: egress ready patterns driven per test.
module tb_hs_rr_dispatch;

    localparam int          NR    = 10000;
    localparam logic [63:0] RBASE = 64'h1000_0000;

    logic aclk  = 1'b0;
    logic reset = 1'b1;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    HandshakeInf #(.T(logic [63:0])) s4 ();
    HandshakeInf #(.T(logic [63:0])) m4 [4] ();
    HandshakeInf #(.T(logic [63:0])) s3 ();
    HandshakeInf #(.T(logic [63:0])) m3 [3] ();

    logic [3:0]  rdy4, vld4;
    logic [63:0] dat4 [4];
    logic [2:0]  rdy3, vld3;
    logic [63:0] dat3 [3];
    logic [1:0]  last_port4, last_port3;
    logic        idle4, idle3;

    for (genvar g = 0; g < 4; g++) begin : g_m4
        assign m4[g].ready = rdy4[g];
        assign vld4[g]     = m4[g].valid;
        assign dat4[g]     = m4[g].data;
    end
    for (genvar g = 0; g < 3; g++) begin : g_m3
        assign m3[g].ready = rdy3[g];
        assign vld3[g]     = m3[g].valid;
        assign dat3[g]     = m3[g].data;
    end

`ifdef HS_RR_DISPATCH_STATS_EN
    logic [31:0] dcnt4 [4];
    logic [31:0] stall4;
    logic [31:0] dcnt3 [3];
    logic [31:0] stall3;
`endif

    hs_rr_dispatch #(.N_OUT(4), .STYPE(logic [63:0])) dut (
        .aclk(aclk), .reset(reset), .s_in(s4), .m_out(m4),
        .last_port(last_port4), .idle(idle4)
`ifdef HS_RR_DISPATCH_STATS_EN
        , .dispatch_cnt(dcnt4), .stall_cnt(stall4)
`endif
    );

    hs_rr_dispatch #(.N_OUT(3), .STYPE(logic [63:0])) dut3 (
        .aclk(aclk), .reset(reset), .s_in(s3), .m_out(m3),
        .last_port(last_port3), .idle(idle3)
`ifdef HS_RR_DISPATCH_STATS_EN
        , .dispatch_cnt(dcnt3), .stall_cnt(stall3)
`endif
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    bit abort = 1'b0;

    task automatic send4(input logic [63:0] d);
        bit ok = 1'b0;
        int n  = 0;
        if (abort) return;
        s4.valid = 1'b1;
        s4.data  = d;
        while (!ok && n < 200) begin
            ok = s4.ready;
            tick();
            n++;
        end
        s4.valid = 1'b0;
        if (!ok) begin
            chk("send_accept", {63'd0, ok}, 64'd1);
            abort = 1'b1;
        end
    endtask

    // Egress monitor on the N_OUT=4 instance: logs dispatches and accepts,
    // checks held data stability and scoreboards the random phase.
    logic [3:0]  pv  = '0;
    logic [3:0]  phs = '0;
    logic [63:0] pdat [4];
    int          disp_port [$];
    logic [63:0] disp_dat  [$];
    int          disp_cyc  [$];
    int          acc_cyc   [$];
    bit          rand_on   = 1'b0;
    bit          seen [NR];
    int          delivered = 0;
    int          dup_cnt   = 0;
    int          range_err = 0;
    int          ridx;

    always @(negedge aclk) begin
        if (reset) begin
            pv  = '0;
            phs = '0;
        end else begin
            if (s4.valid && s4.ready) acc_cyc.push_back(cyc);
            for (int i = 0; i < 4; i++) begin
                if (pv[i] && !phs[i]) begin
                    chk("hold_vld", {63'd0, vld4[i]}, 64'd1);
                    chk("hold_dat", dat4[i], pdat[i]);
                end
                if (vld4[i] && (!pv[i] || phs[i])) begin
                    disp_port.push_back(i);
                    disp_dat.push_back(dat4[i]);
                    disp_cyc.push_back(cyc);
                end
                if (rand_on && vld4[i] && rdy4[i]) begin
                    if (dat4[i] < RBASE || dat4[i] >= RBASE + NR) begin
                        range_err++;
                    end else begin
                        ridx = int'(dat4[i] - RBASE);
                        if (seen[ridx]) dup_cnt++;
                        seen[ridx] = 1'b1;
                        delivered++;
                    end
                end
                pv[i]   = vld4[i];
                phs[i]  = vld4[i] && rdy4[i];
                pdat[i] = dat4[i];
            end
        end
    end

    int exp2 [8] = '{0, 1, 2, 3, 0, 2, 3, 0};
    int k, low_cyc, n3, guard, missing, oor;
    int p3 [16];
    logic [63:0] d3 [16];
    bit ok3, rdone;

    initial begin
        s4.valid = 1'b0; s4.data = '0;
        s3.valid = 1'b0; s3.data = '0;
        rdy4 = 4'hF; rdy3 = 3'h7;
        reset = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_s_ready", {63'd0, s4.ready}, 64'd0);
        chk("rst_vld", {60'd0, vld4}, 64'd0);
        chk("rst_dat0", dat4[0], 64'd0);
        chk("rst_idle", {63'd0, idle4}, 64'd1);
        chk("rst_last", {62'd0, last_port4}, 64'd0);
        reset = 1'b0;
        tick();
        chk("rdy_after_rst", {63'd0, s4.ready}, 64'd1);

        // Test 1: back-to-back stream, all outputs ready
        disp_port.delete(); disp_dat.delete(); disp_cyc.delete(); acc_cyc.delete();
        for (int i = 0; i < 8; i++) send4(64'h10 + 64'(i));
        repeat (4) tick();
        chk("t1_ndisp", 64'(disp_port.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_port", 64'(disp_port[i]), 64'(i % 4));
            chk("t1_dat", disp_dat[i], 64'h10 + 64'(i));
        end
        chk("t1_latency", 64'(disp_cyc[0] - acc_cyc[0]), 64'd2);
        chk("t1_rate", 64'(disp_cyc[7] - disp_cyc[0]), 64'd7);
        chk("t1_idle", {63'd0, idle4}, 64'd1);
        chk("t1_last", {62'd0, last_port4}, 64'd3);
`ifdef HS_RR_DISPATCH_STATS_EN
        chk("t1_dcnt0", {32'd0, dcnt4[0]}, 64'd2);
        chk("t1_dcnt3", {32'd0, dcnt4[3]}, 64'd2);
`endif

        // Test 2: port 1 blocked
        rdy4 = 4'b1101;
        disp_port.delete(); disp_dat.delete(); disp_cyc.delete();
        for (int i = 0; i < 8; i++) send4(64'h20 + 64'(i));
        repeat (4) tick();
        chk("t2_ndisp", 64'(disp_port.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_port", 64'(disp_port[i]), 64'(exp2[i]));
            chk("t2_dat", disp_dat[i], 64'h20 + 64'(i));
        end
        chk("t2_p1_vld", {63'd0, vld4[1]}, 64'd1);
        chk("t2_p1_dat", dat4[1], 64'h21);
        chk("t2_last", {62'd0, last_port4}, 64'd0);
        rdy4 = 4'hF;
        repeat (3) tick();
        chk("t2_idle", {63'd0, idle4}, 64'd1);

        // Test 3: everything blocked, continuous offer
        rdy4 = 4'h0;
        disp_port.delete(); disp_dat.delete(); disp_cyc.delete(); acc_cyc.delete();
        k = 0; low_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            s4.valid = 1'b1;
            s4.data  = 64'h30 + 64'(k);
            ok3 = s4.ready;
            if (!ok3 && low_cyc < 0) low_cyc = cyc;
            tick();
            if (ok3) k++;
        end
        s4.valid = 1'b0;
        chk("t3_accepts", 64'(k), 64'd6);
        chk("t3_acc_log", 64'(acc_cyc.size()), 64'd6);
        chk("t3_ready_drop", 64'(low_cyc - acc_cyc[5]), 64'd1);
        chk("t3_s_ready", {63'd0, s4.ready}, 64'd0);
        chk("t3_vld", {60'd0, vld4}, 64'hF);
        chk("t3_ndisp", 64'(disp_port.size()), 64'd4);
        chk("t3_port0", 64'(disp_port[0]), 64'd1);
        chk("t3_port3", 64'(disp_port[3]), 64'd0);
`ifdef HS_RR_DISPATCH_STATS_EN
        chk("t3_stall", {32'd0, stall4}, 64'd7);
        chk("t3_dcnt0", {32'd0, dcnt4[0]}, 64'd6);
        chk("t3_dcnt1", {32'd0, dcnt4[1]}, 64'd4);
`endif

        // Test 4: reset with items in flight
        rdy4 = 4'hF;
        repeat (6) tick();
        chk("t4_drained", {63'd0, idle4}, 64'd1);
        rdy4 = 4'h0;
        for (int i = 0; i < 3; i++) send4(64'h50 + 64'(i));
        tick();
        chk("t4_busy", {63'd0, idle4}, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_vld", {60'd0, vld4}, 64'd0);
        chk("t4_idle", {63'd0, idle4}, 64'd1);
        chk("t4_last", {62'd0, last_port4}, 64'd0);
        chk("t4_s_ready_lo", {63'd0, s4.ready}, 64'd0);
        tick();
        chk("t4_s_ready_hi", {63'd0, s4.ready}, 64'd1);
        rdy4 = 4'hF;
        disp_port.delete(); disp_dat.delete(); disp_cyc.delete();
        send4(64'h60);
        repeat (3) tick();
        chk("t4_ndisp", 64'(disp_port.size()), 64'd1);
        chk("t4_port", 64'(disp_port[0]), 64'd0);
        chk("t4_dat", disp_dat[0], 64'h60);
`ifdef HS_RR_DISPATCH_STATS_EN
        chk("t4_dcnt0", {32'd0, dcnt4[0]}, 64'd1);
        chk("t4_stall", {32'd0, stall4}, 64'd0);
`endif

        // Test 5: N_OUT=3 wrap
        k = 0; n3 = 0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (vld3[i] && n3 < 16) begin
                    p3[n3] = i;
                    d3[n3] = dat3[i];
                    n3++;
                end
            end
            s3.valid = (k < 7);
            s3.data  = 64'h70 + 64'(k);
            ok3 = s3.ready && (k < 7);
            tick();
            if (ok3) k++;
        end
        s3.valid = 1'b0;
        chk("t5_n", 64'(n3), 64'd7);
        for (int i = 0; i < 7; i++) begin
            chk("t5_port", 64'(p3[i]), 64'(i % 3));
            chk("t5_dat", d3[i], 64'h70 + 64'(i));
        end
        chk("t5_last", {62'd0, last_port3}, 64'd0);
        chk("t5_idle", {63'd0, idle3}, 64'd1);

        // Test 6: random egress ready, 10k items
        disp_port.delete(); disp_dat.delete(); disp_cyc.delete();
        delivered = 0; rdone = 1'b0; guard = 0;
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < NR && !abort; i++) send4(RBASE + 64'(i));
                rdone = 1'b1;
            end
            begin
                while (!(rdone && delivered >= NR) && guard < 60000) begin
                    rdy4 = 4'($urandom);
                    tick();
                    guard++;
                end
                if (guard >= 60000) abort = 1'b1;
            end
        join
        rdy4 = 4'hF;
        repeat (5) tick();
        rand_on = 1'b0;
        missing = 0;
        for (int i = 0; i < NR; i++) if (!seen[i]) missing++;
        oor = 0;
        for (int i = 0; i < disp_dat.size(); i++) if (disp_dat[i] != RBASE + 64'(i)) oor++;
        chk("rand_delivered", 64'(delivered), 64'(NR));
        chk("rand_dup", 64'(dup_cnt), 64'd0);
        chk("rand_range", 64'(range_err), 64'd0);
        chk("rand_missing", 64'(missing), 64'd0);
        chk("rand_ndisp", 64'(disp_dat.size()), 64'(NR));
        chk("rand_order", 64'(oor), 64'd0);
        chk("rand_idle", {63'd0, idle4}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

endmodule
